mcp_spi_arb: RTL and testbench

- Round-robin arbiter and transaction sequencer for the shared MCP2515 SPI port.
- Accepts MCP2515 command descriptors from NREQ requesters (init sequencer, TX loader, RX/interrupt poller) and expands each into a byte sequence.
- Drives the byte-level SPI shifter and owns chip-select, so transactions never interleave on the bus.
- Returns read data and a completion pulse to the requester that was granted.

---
 rtl/mcp_spi_arb_pkg.sv | 70 +++++++
 rtl/mcp_spi_arb_rr_arbiter.sv | 35 +++
 rtl/mcp_spi_arb.sv | 155 +++++++++++++++
 tb/tb_mcp_spi_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_spi_arb_pkg.sv
// Shared definitions for the MCP2515 SPI arbiter: request types, opcodes,
// sequencer states, descriptor layout and default timing values.
// Helper functions expand a latched descriptor into its SPI byte list.
package mcp_pkg;

   localparam logic [2:0] TYPE_CMD    = 3'd0;
   localparam logic [2:0] TYPE_WRITE  = 3'd1;
   localparam logic [2:0] TYPE_READ   = 3'd2;
   localparam logic [2:0] TYPE_BITMOD = 3'd3;
   localparam logic [2:0] TYPE_STATUS = 3'd4;

   localparam logic [7:0] OP_RESET  = 8'hC0;
   localparam logic [7:0] OP_WRITE  = 8'h02;
   localparam logic [7:0] OP_READ   = 8'h03;
   localparam logic [7:0] OP_BITMOD = 8'h05;
   localparam logic [7:0] OP_STATUS = 8'hA0;
   localparam logic [7:0] OP_RTS0   = 8'h81;
   localparam logic [7:0] OP_RTS1   = 8'h82;
   localparam logic [7:0] OP_RTS2   = 8'h84;

   localparam int DEF_CS_SETUP = 50;
   localparam int DEF_CS_GAP   = 500;
   localparam int DEF_TIMEOUT  = 16383;

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_SETUP, S_SEND, S_WAIT, S_HOLD, S_GAP
   } state_t;

   typedef struct packed {
      logic [2:0]  typ;
      logic [7:0]  cmd;
      logic [7:0]  addr;
      logic [15:0] wdata;   // {mask, data}
   } desc_t;

   // Total bytes on the wire, including the trailing dummy for reads.
   function automatic logic [2:0] byte_total(input logic [2:0] typ);
      case (typ)
         TYPE_CMD:    return 3'd1;
         TYPE_WRITE:  return 3'd3;
         TYPE_READ:   return 3'd3;
         TYPE_BITMOD: return 3'd4;
         TYPE_STATUS: return 3'd2;
         default:     return 3'd0;
      endcase
   endfunction

   // Types whose last (dummy) byte carries the read-back value.
   function automatic logic has_rx(input logic [2:0] typ);
      return (typ == TYPE_READ) || (typ == TYPE_STATUS);
   endfunction

   // Byte number idx of the transaction described by d.
   function automatic logic [7:0] tx_byte(input desc_t d, input logic [2:0] idx);
      case (idx)
         3'd0: return d.cmd;
         3'd1: return (d.typ == TYPE_STATUS) ? 8'h00 : d.addr;
         3'd2: begin
            case (d.typ)
               TYPE_WRITE:  return d.wdata[7:0];
               TYPE_BITMOD: return d.wdata[15:8];
               default:     return 8'h00;
            endcase
         end
         3'd3:    return d.wdata[7:0];
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/mcp_spi_arb_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Zero latency; no state, the caller owns and advances the pointer.
// Returns one-hot winner, its index, and a valid flag.
module mcp_rr_arbiter #(
   parameter int NREQ = 3,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [PW-1:0]   win_idx,
   output logic            vld
);

   // Scan requesters starting at ptr with wrap-around; first hit wins.
   always_comb begin
      int          j;
      logic [PW-1:0] jj;
      win     = '0;
      win_idx = '0;
      vld     = 1'b0;
      j       = 0;
      jj      = '0;
      for (int i = 0; i < NREQ; i++) begin
         j  = (int'(ptr) + i) % NREQ;
         jj = PW'(j);
         if (!vld && req[jj]) begin
            vld     = 1'b1;
            win[jj] = 1'b1;
            win_idx = jj;
         end
      end
   end

endmodule

// File: rtl/mcp_spi_arb.sv
// Round-robin arbiter/sequencer owning the MCP2515 SPI port and chip select.
// Grant 1 cycle after req when idle; transaction = setup + bytes + hold + gap.
// Waits on eng_done per byte; MCP_ARB_TIMEOUT_EN adds a per-byte timeout abort.
module mcp_spi_arb
   import mcp_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int CS_SETUP = DEF_CS_SETUP,
   parameter int CS_GAP   = DEF_CS_GAP,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic              clk50,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] req_type,
   input  logic [8*NREQ-1:0] req_cmd,
   input  logic [8*NREQ-1:0] req_addr,
   input  logic [16*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [7:0]        rdata,
   output logic              err,
   output logic              busy,
   output logic              spi_cs_n,
   output logic              eng_start,
   output logic [7:0]        eng_tx,
   input  logic              eng_done,
   input  logic [7:0]        eng_rx
);

   localparam int PW      = $clog2(NREQ);
   localparam int MAX_A   = (CS_GAP > CS_SETUP) ? CS_GAP : CS_SETUP;
   localparam int CNT_MAX = (TIMEOUT > MAX_A) ? TIMEOUT : MAX_A;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t            state, nstate;
   desc_t             desc, sel;
   logic [NREQ-1:0]   win_oh;
   logic [PW-1:0]     ptr;
   logic [NREQ-1:0]   arb_win;
   logic [PW-1:0]     arb_idx;
   logic              arb_vld;
   logic [2:0]        idx, send_idx, total;
   logic [CNT_W-1:0]  cnt;
   logic              invalid, last_byte, to_hit;
   logic              cs_n_nxt, start_nxt, err_nxt, busy_nxt;
   logic [NREQ-1:0]   gnt_nxt, done_nxt;

   mcp_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req     (req),
      .ptr     (ptr),
      .win     (arb_win),
      .win_idx (arb_idx),
      .vld     (arb_vld)
   );

   assign total     = byte_total(desc.typ);
   assign invalid   = desc.typ > TYPE_STATUS;
   assign last_byte = (idx + 3'd1) >= total;
   assign send_idx  = (state == S_WAIT) ? idx + 3'd1 : idx;

`ifdef MCP_ARB_TIMEOUT_EN
   assign to_hit = (state == S_WAIT) && !eng_done && (cnt == CNT_W'(TIMEOUT - 1));
`else
   assign to_hit = 1'b0;
`endif

   // Mux the winning requester's descriptor fields.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_win[i]) begin
            sel.typ   = req_type[i*3 +: 3];
            sel.cmd   = req_cmd[i*8 +: 8];
            sel.addr  = req_addr[i*8 +: 8];
            sel.wdata = req_wdata[i*16 +: 16];
         end
      end
   end

   // State register.
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nstate;
   end

   // Next-state logic.
   always_comb begin
      nstate = state;
      case (state)
         S_IDLE:  if (arb_vld) nstate = S_CHECK;
         S_CHECK: nstate = invalid ? S_IDLE : S_SETUP;
         S_SETUP: if (cnt == CNT_W'(CS_SETUP - 1)) nstate = S_SEND;
         S_SEND:  nstate = S_WAIT;
         S_WAIT: begin
            if (eng_done)    nstate = last_byte ? S_HOLD : S_SEND;
            else if (to_hit) nstate = S_GAP;
         end
         S_HOLD:  nstate = S_GAP;
         S_GAP:   if (cnt == CNT_W'(CS_GAP - 1)) nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   // Output decode: registered outputs follow the state being entered.
   always_comb begin
      cs_n_nxt  = !(nstate inside {S_SETUP, S_SEND, S_WAIT, S_HOLD});
      start_nxt = (nstate == S_SEND);
      busy_nxt  = (nstate != S_IDLE);
      gnt_nxt   = (state == S_IDLE && arb_vld) ? arb_win : '0;
      err_nxt   = (state == S_CHECK && invalid) || to_hit;
      done_nxt  = ((state == S_CHECK && invalid) || state == S_HOLD || to_hit) ? win_oh : '0;
   end

   // Output registers, descriptor latch, counters and read capture.
   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         spi_cs_n  <= 1'b1;
         eng_start <= 1'b0;
         eng_tx    <= 8'h00;
         gnt       <= '0;
         done      <= '0;
         err       <= 1'b0;
         busy      <= 1'b0;
         rdata     <= 8'h00;
         ptr       <= '0;
         desc      <= '0;
         win_oh    <= '0;
         idx       <= 3'd0;
         cnt       <= '0;
      end else begin
         spi_cs_n  <= cs_n_nxt;
         eng_start <= start_nxt;
         gnt       <= gnt_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         busy      <= busy_nxt;
         if (nstate == S_SEND) eng_tx <= tx_byte(desc, send_idx);
         if (state == S_IDLE && arb_vld) begin
            desc   <= sel;
            win_oh <= arb_win;
            ptr    <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
         end
         if (state == S_CHECK) idx <= 3'd0;
         else if (state == S_WAIT && eng_done) begin
            idx <= idx + 3'd1;
            if (last_byte && has_rx(desc.typ)) rdata <= eng_rx;
         end
         // Each state times itself from zero; counter saturates, never wraps.
         if (nstate != state)  cnt <= '0;
         else if (cnt != '1)   cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mcp_spi_arb.sv
// Directed self-checking bench for mcp_spi_arb with a behavioural SPI engine.
// The engine answers each eng_start with eng_done after eng_delay cycles.
module tb_mcp_spi_arb;

   logic        clk50 = 1'b0;
   logic        rst_n;
   logic [2:0]  req;
   logic [8:0]  req_type;
   logic [23:0] req_cmd, req_addr;
   logic [47:0] req_wdata;
   logic [2:0]  gnt, done;
   logic [7:0]  rdata, eng_tx, eng_rx;
   logic        err, busy, spi_cs_n, eng_start, eng_done;

   int n_checks = 0;
   int n_fail   = 0;

   int       eng_delay = 400;
   bit       eng_mute  = 0;
   logic [7:0] rx_value = 8'h80;
   int       eng_cnt = 0;
   logic [7:0] eng_last;
   logic [7:0] tx_log[$];
   int       start_cnt = 0;
   int       cyc = 0;
   int       last_start_cyc = 0;

   int       gnt_log[$];
   int       done_log[$];
   int       cs_falls = 0, hi_run = 0, lo_run = 0, last_gap = 0, setup_meas = 0;
   bit       cs_prev = 1, start_seen = 0;

   mcp_spi_arb #(.NREQ(3), .CS_SETUP(50), .CS_GAP(500), .TIMEOUT(16383)) dut (
      .clk50(clk50), .rst_n(rst_n), .req(req), .req_type(req_type), .req_cmd(req_cmd),
      .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata),
      .err(err), .busy(busy), .spi_cs_n(spi_cs_n), .eng_start(eng_start), .eng_tx(eng_tx),
      .eng_done(eng_done), .eng_rx(eng_rx)
   );

   always #10 clk50 = ~clk50;
   always @(posedge clk50) cyc++;

   function automatic int oh2i(input logic [2:0] v);
      for (int i = 0; i < 3; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Behavioural byte engine: logs every eng_start, replies after eng_delay cycles.
   initial begin
      eng_done = 1'b0;
      eng_rx   = 8'h00;
      forever begin
         @(negedge clk50 or negedge rst_n);
         eng_done = 1'b0;
         if (!rst_n) eng_cnt = 0;
         else begin
            if (eng_cnt > 0) begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                  eng_rx   = (eng_last == 8'h00) ? rx_value : 8'h55;
                  eng_done = 1'b1;
               end
            end
            if (eng_start === 1'b1) begin
               eng_last = eng_tx;
               tx_log.push_back(eng_tx);
               start_cnt++;
               last_start_cyc = cyc;
               if (!eng_mute) eng_cnt = eng_delay;
            end
         end
      end
   end

   // Bus monitor: grant/done order, chip-select windows and setup time.
   initial begin
      forever begin
         @(negedge clk50);
         if (gnt != 0)  gnt_log.push_back(oh2i(gnt));
         if (done != 0) done_log.push_back(oh2i(done));
         if (!spi_cs_n) begin
            if (cs_prev) begin
               cs_falls++;
               last_gap   = hi_run;
               lo_run     = 0;
               start_seen = 0;
            end
            if (eng_start && !start_seen) begin
               setup_meas = lo_run;
               start_seen = 1;
            end
            lo_run++;
         end else begin
            if (!cs_prev) hi_run = 0;
            hi_run++;
         end
         cs_prev = spi_cs_n;
      end
   end

   task automatic set_req(input int r, input logic [2:0] t, input logic [7:0] c,
                          input logic [7:0] a, input logic [15:0] wd);
      req_type[r*3 +: 3]   = t;
      req_cmd[r*8 +: 8]    = c;
      req_addr[r*8 +: 8]   = a;
      req_wdata[r*16 +: 16] = wd;
      req[r]               = 1'b1;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (done != 0) begin ok = 1; break; end
         @(negedge clk50);
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (!busy) begin ok = 1; break; end
         @(negedge clk50);
      end
   endtask

   function automatic logic [31:0] bytes_from(input int s0);
      logic [31:0] g = 0;
      for (int i = s0; i < tx_log.size() && i < s0 + 4; i++) g = {g[23:0], tx_log[i]};
      return g;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; req = 0; req_type = 0; req_cmd = 0; req_addr = 0; req_wdata = 0;
      repeat (3) @(negedge clk50);
      n_checks++; if ({spi_cs_n, eng_start, busy, err} !== 4'b1000) begin n_fail++;
         $display("FAIL reset_ctrl: got cs/start/busy/err=%b expected 1000", {spi_cs_n, eng_start, busy, err}); end
      n_checks++; if ({gnt, done} !== 6'b0) begin n_fail++;
         $display("FAIL reset_gnt_done: got %b expected 000000", {gnt, done}); end
      n_checks++; if ({eng_tx, rdata} !== 16'h0) begin n_fail++;
         $display("FAIL reset_data: got eng_tx/rdata=%h expected 0000", {eng_tx, rdata}); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk50);
      n_checks++; if ({spi_cs_n, busy, gnt} !== 5'b10000) begin n_fail++;
         $display("FAIL idle_after_reset: got %b expected 10000", {spi_cs_n, busy, gnt}); end
   endtask

   task automatic test_write();
      int s0, f0, n; bit ok, bad;
      s0 = tx_log.size(); f0 = cs_falls;
      set_req(0, 3'd1, 8'h02, 8'h2A, 16'h0003);
      @(negedge clk50);
      n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL write_gnt: got %b expected 001", gnt); end
      req[0] = 1'b0;
      wait_done(5000, ok);
      n_checks++; if (!ok || done !== 3'b001 || err !== 1'b0) begin n_fail++;
         $display("FAIL write_done: got ok=%0d done=%b err=%b expected 1 001 0", ok, done, err); end
      n_checks++; if (tx_log.size() != s0 + 3 || bytes_from(s0) !== 32'h00022A03) begin n_fail++;
         $display("FAIL write_bytes: got %0d bytes %h expected 3 bytes 00022a03", tx_log.size() - s0, bytes_from(s0)); end
      n_checks++; if (setup_meas != 50) begin n_fail++; $display("FAIL write_setup: got %0d expected 50", setup_meas); end
      n_checks++; if (cs_falls != f0 + 1) begin n_fail++; $display("FAIL write_cs_windows: got %0d expected 1", cs_falls - f0); end
      bad = 0; n = 0;
      while (busy && n < 2000) begin if (spi_cs_n !== 1'b1) bad = 1; n++; @(negedge clk50); end
      n_checks++; if (n != 500 || bad) begin n_fail++; $display("FAIL write_gap: got %0d cycles cs_low=%0d expected 500 0", n, bad); end
   endtask

   task automatic test_read();
      int s0; bit ok;
      s0 = tx_log.size(); rx_value = 8'h80;
      set_req(1, 3'd2, 8'h03, 8'h0E, 16'h0000);
      @(negedge clk50);
      n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL read_gnt: got %b expected 010", gnt); end
      req[1] = 1'b0;
      wait_done(5000, ok);
      n_checks++; if (!ok || done !== 3'b010 || rdata !== 8'h80) begin n_fail++;
         $display("FAIL read_data: got ok=%0d done=%b rdata=%h expected 1 010 80", ok, done, rdata); end
      n_checks++; if (tx_log.size() != s0 + 3 || bytes_from(s0) !== 32'h00030E00) begin n_fail++;
         $display("FAIL read_bytes: got %0d bytes %h expected 3 bytes 00030e00", tx_log.size() - s0, bytes_from(s0)); end
      n_checks++; if (last_gap != 502) begin n_fail++; $display("FAIL read_cs_gap: got %0d expected 502", last_gap); end
      wait_idle(1000, ok);
   endtask

   task automatic test_bitmod();
      int s0, f0; bit ok;
      s0 = tx_log.size(); f0 = cs_falls; rx_value = 8'hA5;
      set_req(2, 3'd3, 8'h05, 8'h2C, 16'h0100);
      @(negedge clk50);
      n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL bitmod_gnt: got %b expected 100", gnt); end
      req[2] = 1'b0;
      wait_done(5000, ok);
      n_checks++; if (!ok || done !== 3'b100 || rdata !== 8'h80) begin n_fail++;
         $display("FAIL bitmod_done: got ok=%0d done=%b rdata=%h expected 1 100 80", ok, done, rdata); end
      n_checks++; if (tx_log.size() != s0 + 4 || bytes_from(s0) !== 32'h052C0100) begin n_fail++;
         $display("FAIL bitmod_bytes: got %0d bytes %h expected 4 bytes 052c0100", tx_log.size() - s0, bytes_from(s0)); end
      n_checks++; if (cs_falls != f0 + 1) begin n_fail++; $display("FAIL bitmod_cs_windows: got %0d expected 1", cs_falls - f0); end
      wait_idle(1000, ok);
   endtask

   task automatic test_invalid();
      int s0, f0;
      s0 = start_cnt; f0 = cs_falls;
      set_req(0, 3'd6, 8'h00, 8'h00, 16'h0000);
      @(negedge clk50);
      n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL invalid_gnt: got %b expected 001", gnt); end
      req[0] = 1'b0;
      @(negedge clk50);
      n_checks++; if (done !== 3'b001 || err !== 1'b1) begin n_fail++;
         $display("FAIL invalid_done_err: got done=%b err=%b expected 001 1", done, err); end
      @(negedge clk50);
      n_checks++; if (done !== 3'b000 || err !== 1'b0 || busy !== 1'b0) begin n_fail++;
         $display("FAIL invalid_pulse: got done=%b err=%b busy=%b expected 000 0 0", done, err, busy); end
      repeat (100) @(negedge clk50);
      n_checks++; if (cs_falls != f0 || start_cnt != s0) begin n_fail++;
         $display("FAIL invalid_no_bus: got cs_falls=%0d starts=%0d expected 0 0", cs_falls - f0, start_cnt - s0); end
   endtask

   task automatic test_round_robin();
      int g0, d0; bit ok;
      for (int pass = 0; pass < 2; pass++) begin
         g0 = gnt_log.size(); d0 = done_log.size();
         if (pass == 0) rst_n = 1'b0;
         set_req(0, 3'd0, 8'h81, 8'h00, 16'h0);
         set_req(1, 3'd0, 8'h82, 8'h00, 16'h0);
         set_req(2, 3'd0, 8'h84, 8'h00, 16'h0);
         if (pass == 0) begin @(negedge clk50); rst_n = 1'b1; end
         @(negedge clk50);
         n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL rr_first_gnt pass%0d: got %b expected 001", pass, gnt); end
         for (int i = 0; i < 8000 && gnt_log.size() < g0 + 3; i++) begin
            req = req & ~gnt;
            @(negedge clk50);
         end
         req = req & ~gnt;
         wait_idle(3000, ok);
         n_checks++; if (gnt_log.size() != g0 + 3 || gnt_log[g0] != 0 || gnt_log[g0+1] != 1 || gnt_log[g0+2] != 2) begin
            n_fail++; $display("FAIL rr_order pass%0d: got %0d grants expected order 0,1,2", pass, gnt_log.size() - g0); end
         n_checks++; if (!ok || done_log.size() != d0 + 3 || done_log[d0] != 0 || done_log[d0+2] != 2) begin
            n_fail++; $display("FAIL rr_done pass%0d: got %0d dones idle=%0d expected 3 1", pass, done_log.size() - d0, ok); end
      end
   endtask

   task automatic test_reset_mid();
      int s0, d0; bit ok;
      s0 = start_cnt;
      set_req(0, 3'd1, 8'h02, 8'h31, 16'h00AA);
      @(negedge clk50);
      req[0] = 1'b0;
      set_req(1, 3'd0, 8'h81, 8'h00, 16'h0);
      for (int i = 0; i < 3000 && start_cnt < s0 + 2; i++) @(negedge clk50);
      repeat (50) @(negedge clk50);
      d0 = done_log.size();
      n_checks++; if (spi_cs_n !== 1'b0 || start_cnt != s0 + 2) begin n_fail++;
         $display("FAIL rstmid_pre: got cs_n=%b starts=%0d expected 0 2", spi_cs_n, start_cnt - s0); end
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin n_fail++;
         $display("FAIL rstmid_async: got cs_n=%b busy=%b expected 1 0", spi_cs_n, busy); end
      repeat (3) @(negedge clk50);
      rst_n = 1'b1;
      @(negedge clk50);
      n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL rstmid_regrant: got %b expected 010", gnt); end
      req[1] = 1'b0;
      wait_done(3000, ok);
      n_checks++; if (!ok || done !== 3'b010 || done_log.size() != d0 + 1) begin n_fail++;
         $display("FAIL rstmid_done: got ok=%0d done=%b count=%0d expected 1 010 1", ok, done, done_log.size() - d0); end
      wait_idle(1000, ok);
   endtask

`ifdef MCP_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      eng_mute = 1;
      set_req(2, 3'd4, 8'hA0, 8'h00, 16'h0);
      @(negedge clk50);
      req[2] = 1'b0;
      wait_done(20000, ok);
      n_checks++; if (!ok || done !== 3'b100 || err !== 1'b1 || spi_cs_n !== 1'b1 || rdata !== 8'h00) begin n_fail++;
         $display("FAIL timeout_abort: got ok=%0d done=%b err=%b cs_n=%b rdata=%h expected 1 100 1 1 00", ok, done, err, spi_cs_n, rdata); end
      n_checks++; if (cyc - last_start_cyc != 16384) begin n_fail++;
         $display("FAIL timeout_len: got %0d expected 16384", cyc - last_start_cyc); end
      eng_mute = 0;
      wait_idle(1000, ok);
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bitmod();
      test_invalid();
      test_round_robin();
      test_reset_mid();
`ifdef MCP_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
